// File: rtl/bcd_time_counter_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
package bcd_time_counter_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_field_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam bcd_digit_t MAX_SEC_TENS = 4'd5;
    localparam bcd_digit_t MAX_ONES     = 4'd9;

    function automatic bcd_field_t to_bcd(input int value);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = bcd_digit_t'(value / 10);
        ones = bcd_digit_t'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after MODULUS-1.
// carry pulses combinationally when an increment wraps the field.
module bcd_mod_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int MODULUS     = 60,
    parameter int RESET_VALUE = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] value,
    output logic       carry
);

    localparam bcd_field_t LAST = to_bcd(MODULUS - 1);
    localparam bcd_field_t INIT = to_bcd(RESET_VALUE);

    bcd_digit_t tens;
    bcd_digit_t ones;
    bcd_field_t next_value;
    logic       at_last;

    assign tens    = value[7:4];
    assign ones    = value[3:0];
    assign at_last = (value == LAST);
    assign carry   = inc && !clear && at_last;

    always_comb begin
        next_value = value;
        if (clear) begin
            next_value = '0;
        end else if (inc) begin
            if (at_last) begin
                next_value = '0;
            end else if (ones >= MAX_ONES) begin
                next_value = {tens + 4'd1, 4'd0};
            end else begin
                next_value = {tens, ones + 4'd1};
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            value <= INIT;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS packed-BCD time-of-day counter with a push-button SET mode.
// Define ALARM_EN to add the alarm compare, alarm_ack input and alarm_out flag.
//
// state  | meaning
// ST_RUN | ticks advance seconds with carry into minutes and hours
// ST_SET | ticks ignored; button edges step minutes and hours independently
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24,
    parameter int START_HOUR    = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       running,
    output logic       day_wrap
`ifdef ALARM_EN
    ,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_ack,
    output logic       alarm_out
`endif
);

    localparam int SEXAGESIMAL = (int'(MAX_SEC_TENS) + 1) * 10;

    state_t state_q;
    state_t state_d;
    logic   prev_min;
    logic   prev_hour;
    logic   edge_min;
    logic   edge_hour;
    logic   in_run;
    logic   in_set;
    logic   enter_set;
    logic   sec_inc;
    logic   min_inc;
    logic   hour_inc;
    logic   sec_carry;
    logic   min_carry;
    logic   hour_carry;

    assign edge_min  = inc_min  & ~prev_min;
    assign edge_hour = inc_hour & ~prev_hour;
    assign in_run    = (state_q == ST_RUN);
    assign in_set    = (state_q == ST_SET);
    assign running   = in_run;

    // A tick sampled together with the request to enter SET is dropped.
    assign enter_set = in_run && set_mode;
    assign sec_inc   = in_run && !set_mode && tick;
    assign min_inc   = in_set ? edge_min  : sec_carry;
    assign hour_inc  = in_set ? edge_hour : min_carry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (set_mode)  state_d = ST_SET;
            ST_SET:  if (!set_mode) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            prev_min  <= 1'b0;
            prev_hour <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_min  <= inc_min;
            prev_hour <= inc_hour;
            day_wrap  <= in_run && hour_carry;
        end
    end

    bcd_mod_counter #(.MODULUS(SEXAGESIMAL), .RESET_VALUE(0)) u_sec (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .inc      (sec_inc),
        .clear    (enter_set),
        .value    (sec_bcd),
        .carry    (sec_carry)
    );

    bcd_mod_counter #(.MODULUS(SEXAGESIMAL), .RESET_VALUE(0)) u_min (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .inc      (min_inc),
        .clear    (1'b0),
        .value    (min_bcd),
        .carry    (min_carry)
    );

    bcd_mod_counter #(.MODULUS(HOURS_PER_DAY), .RESET_VALUE(START_HOUR)) u_hour (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .inc      (hour_inc),
        .clear    (1'b0),
        .value    (hour_bcd),
        .carry    (hour_carry)
    );

`ifdef ALARM_EN
    logic alarm_match;
    logic alarm_match_q;

    // Fire only on the first cycle of a match so an ack inside second 00 sticks.
    assign alarm_match = (hour_bcd == alarm_hour) && (min_bcd == alarm_min) &&
                         (sec_bcd == 8'h00);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            alarm_out     <= 1'b0;
            alarm_match_q <= 1'b0;
        end else begin
            alarm_match_q <= alarm_match;
            if (alarm_ack || enter_set) begin
                alarm_out <= 1'b0;
            end else if (in_run && alarm_match && !alarm_match_q) begin
                alarm_out <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_bcd_time_counter;

    localparam int HPD = 24;

    logic       CLOCK_50;
    logic       reset;
    logic       tick;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       running;
    logic       day_wrap;
    logic       ack_drv;
`ifdef ALARM_EN
    logic [7:0] alarm_hour;
    logic [7:0] alarm_min;
    logic       alarm_ack;
    logic       alarm_out;
`endif

    bcd_time_counter #(.HOURS_PER_DAY(HPD), .START_HOUR(0)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick),
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .sec_bcd  (sec_bcd),
        .min_bcd  (min_bcd),
        .hour_bcd (hour_bcd),
        .running  (running),
        .day_wrap (day_wrap)
`ifdef ALARM_EN
        ,
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_ack  (alarm_ack),
        .alarm_out  (alarm_out)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic       run;
        logic       wrap;
        logic       alarm;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, integers rather than BCD.
    int m_sec, m_min, m_hour;
    int m_run, m_wrap, m_pmin, m_phour, m_alarm, m_match_q;
    int a_hour = 0;
    int a_min  = 1;
    logic g_sm = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic t, input logic sm,
                              input logic im, input logic ih, input logic ack);
        int em, eh, match;
        if (!rst) begin
            m_sec = 0; m_min = 0; m_hour = 0;
            m_run = 1; m_wrap = 0; m_pmin = 0; m_phour = 0;
            m_alarm = 0; m_match_q = 0;
        end else begin
            match = (m_hour == a_hour && m_min == a_min && m_sec == 0) ? 1 : 0;
            if (ack || (m_run != 0 && sm)) m_alarm = 0;
            else if (m_run != 0 && match != 0 && m_match_q == 0) m_alarm = 1;
            m_match_q = match;
            m_wrap = 0;
            em = (im && m_pmin == 0) ? 1 : 0;
            eh = (ih && m_phour == 0) ? 1 : 0;
            m_pmin  = im ? 1 : 0;
            m_phour = ih ? 1 : 0;
            if (m_run != 0) begin
                if (sm) begin
                    m_run = 0;
                    m_sec = 0;
                end else if (t) begin
                    m_sec++;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min++;
                        if (m_min == 60) begin
                            m_min = 0;
                            m_hour++;
                            if (m_hour == HPD) begin
                                m_hour = 0;
                                m_wrap = 1;
                            end
                        end
                    end
                end
            end else begin
                if (em != 0) m_min  = (m_min + 1) % 60;
                if (eh != 0) m_hour = (m_hour + 1) % HPD;
                if (!sm) m_run = 1;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic t, input logic sm,
                         input logic im, input logic ih, input logic ack);
        exp_t e;
        reset = rst; tick = t; set_mode = sm;
        inc_min = im; inc_hour = ih; ack_drv = ack;
`ifdef ALARM_EN
        alarm_ack = ack;
`endif
        model_step(rst, t, sm, im, ih, ack);
        e.sec = bcd8(m_sec); e.min = bcd8(m_min); e.hour = bcd8(m_hour);
        e.run = (m_run != 0); e.wrap = (m_wrap != 0); e.alarm = (m_alarm != 0);
        sb_q.push_back(e);
        @(posedge CLOCK_50);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_sec",  sec_bcd,  e.sec);
            chk("sb_min",  min_bcd,  e.min);
            chk("sb_hour", hour_bcd, e.hour);
            chk("sb_run",  8'(running),  8'(e.run));
            chk("sb_wrap", 8'(day_wrap), 8'(e.wrap));
`ifdef ALARM_EN
            chk("sb_alarm", 8'(alarm_out), 8'(e.alarm));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, g_sm, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, g_sm, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, g_sm, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, g_sm, 1'b1, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, g_sm, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, g_sm, 1'b0, 1'b1, 1'b0);
            cycle(1'b1, 1'b0, g_sm, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; set_mode = 1'b0;
        inc_min = 1'b0; inc_hour = 1'b0; ack_drv = 1'b0;
`ifdef ALARM_EN
        alarm_hour = 8'h00; alarm_min = 8'h01; alarm_ack = 1'b0;
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_sec",  sec_bcd,  8'h00);
        chk("rst_hour", hour_bcd, 8'h00);
        chk("rst_run",  8'(running),  8'd1);
        chk("rst_wrap", 8'(day_wrap), 8'd0);

        // Seconds roll into minutes.
        ticks(59);
        chk("sec59", sec_bcd, 8'h59);
        chk("min00", min_bcd, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sec_roll", sec_bcd, 8'h00);
        chk("min_roll", min_bcd, 8'h01);
        chk("no_wrap",  8'(day_wrap), 8'd0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Preload 23:59 and roll the day.
        g_sm = 1'b1;
        idle(1);
        chk("set_run", 8'(running), 8'd0);
        press_min(58);
        press_hour(23);
        chk("pre_min",  min_bcd,  8'h59);
        chk("pre_hour", hour_bcd, 8'h23);
        g_sm = 1'b0;
        idle(1);
        ticks(59);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("day_sec",  sec_bcd,  8'h00);
        chk("day_min",  min_bcd,  8'h00);
        chk("day_hour", hour_bcd, 8'h00);
        chk("day_wrap", 8'(day_wrap), 8'd1);
        idle(1);
        chk("wrap_1cyc", 8'(day_wrap), 8'd0);

        // Entry to SET with a coincident tick.
        ticks(37);
        chk("sec37", sec_bcd, 8'h37);
        g_sm = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("set_sec", sec_bcd, 8'h00);
        chk("set_run0", 8'(running), 8'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("held_min", min_bcd, 8'h01);
        press_min(58);
        press_min(1);
        chk("min_wrap", min_bcd, 8'h00);
        chk("min_nocarry", hour_bcd, 8'h00);

        // Both buttons together from 09:59.
        press_hour(9);
        press_min(59);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("both_hour", hour_bcd, 8'h10);
        chk("both_min",  min_bcd,  8'h00);
        idle(1);
        g_sm = 1'b0;
        idle(1);
        press_hour(1);
        chk("run_ign_hour", hour_bcd, 8'h10);

        // Reset in the middle of 12:34:56 with a tick present.
        g_sm = 1'b1;
        idle(1);
        press_hour(2);
        press_min(34);
        g_sm = 1'b0;
        idle(1);
        ticks(56);
        chk("t_hour", hour_bcd, 8'h12);
        chk("t_min",  min_bcd,  8'h34);
        chk("t_sec",  sec_bcd,  8'h56);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst_sec",  sec_bcd,  8'h00);
        chk("mrst_min",  min_bcd,  8'h00);
        chk("mrst_hour", hour_bcd, 8'h00);
        chk("mrst_run",  8'(running),  8'd1);
        chk("mrst_wrap", 8'(day_wrap), 8'd0);

        // Alarm at 00:01 from a fresh 00:00:00.
        ticks(59);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("al_min", min_bcd, 8'h01);
`ifdef ALARM_EN
        chk("al_pre", 8'(alarm_out), 8'd0);
`endif
        idle(1);
`ifdef ALARM_EN
        chk("al_rise", 8'(alarm_out), 8'd1);
`endif
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALARM_EN
        chk("al_ack", 8'(alarm_out), 8'd0);
`endif
        idle(2);
        ticks(30);
`ifdef ALARM_EN
        chk("al_norefire", 8'(alarm_out), 8'd0);
`endif
        chk("end_sec", sec_bcd, 8'h30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
